demux64x1_4_reg: RTL and testbench
==================================

// Module: demux64x1_4_reg
// PURPOSE
//   Registered 64-bit 1-to-4 distributor: the write side of the 4-lane 256-bit bus consumed by the
//   64-bit 4:1 selector. Accepts 64-bit words over a valid/ready handshake, steers each word into
//   one of four 64-bit lane registers (addressed or auto-incrementing), and presents the packed
//   256-bit frame with a valid/ready handshake once all four lanes are loaded.
// PARAMETERS
//   WIDTH   64   lane width in bits; the packed bus is 4*WIDTH bits
// PORTS
//   clk        in   1          clock; all state updates on posedge
//   reset      in   1          synchronous, active-low reset
//   auto_inc   in   1          1 = lane from internal pointer; 0 = lane from in_sel
//   in_valid   in   1          producer word valid
//   in_ready   out  1          block can accept a word this cycle
//   in_data    in   WIDTH      word to store
//   in_sel     in   2          target lane when auto_inc = 0
//   lane_vld   out  4          bit k = lane k loaded since the last frame handoff
//   d          out  4*WIDTH    packed lanes; lane k at d[WIDTH*k +: WIDTH]
//   out_valid  out  1          all four lanes loaded
//   out_ready  in   1          consumer takes the frame
//   frame_cnt  out  16         frames handed off (DEMUX64_FRAME_CNT_EN only)
// BEHAVIOUR
//   - Reset (reset==0 at posedge): d=0, lane_vld=0, ptr=0, state=EMPTY, out_valid=0,
//     frame_cnt=0. Takes priority over every other event, including mid-frame; partial frame lost.
//   - FSM states: EMPTY (lane_vld==0), FILL (0<popcount<4), FULL (lane_vld==4'hF).
//     EMPTY -write-> FILL; FILL -write completing 4th lane-> FULL;
//     FULL -out_valid&&out_ready-> EMPTY.
//   - in_ready = (state != FULL); combinational from state only, independent of in_valid.
//   - Write accepted when in_valid && in_ready at posedge. Target lane t = auto_inc ? ptr : in_sel.
//     d[t] <= in_data, lane_vld[t] <= 1. Visible on d one cycle after the accepting edge.
//   - Pointer: on an accepted write with auto_inc=1, ptr <= ptr+1 (2-bit, wraps 3->0).
//     Addressed writes leave ptr unchanged.
//   - Overwrite: addressed write to a lane already loaded replaces data; lane_vld unchanged,
//     no state change.
//   - out_valid = (state == FULL). Frame handoff on out_valid && out_ready: lane_vld<=0, ptr<=0,
//     state<=EMPTY. d is NOT cleared; it holds old data until overwritten.
//   - Simultaneous in_valid with handoff: in_ready is 0 in FULL, so no write that cycle; first
//     new write is accepted the cycle after handoff (1-cycle bubble, by design).
//   - out_ready while not FULL is ignored. in_sel ignored when auto_inc=1.
//   - auto_inc may change between words; mixed mode is legal and uses the rules above per word.
//   - Outputs d, lane_vld, out_valid, frame_cnt are registered or decoded only from state regs.
// CONFIGURATION
//   DEMUX64_FRAME_CNT_EN defined: frame_cnt increments by 1 on each handoff, wraps 16'hFFFF->0,
//     cleared by reset.
//   Not defined: frame_cnt tied to 16'h0; no counter flops synthesised. Port always present.
// TESTING
//   1. Reset: hold reset=0 for 2 cycles with in_valid=1 -> d=0, lane_vld=0, out_valid=0,
//      in_ready=1.
//   2. Auto fill: auto_inc=1, write 64'hA0,A1,A2,A3 back-to-back -> after 4th edge
//      d=={A3,A2,A1,A0}, lane_vld=4'hF, out_valid=1, in_ready=0.
//   3. Addressed + overwrite: auto_inc=0, sel=2 data 64'h22, sel=2 data 64'h33 -> lane_vld=4'b0100,
//      d[191:128]=64'h33; then sel 0,1,3 -> FULL.
//   4. Backpressure/handoff: FULL with out_ready=0 for 5 cycles, in_valid=1 -> no writes, d stable;
//      out_ready=1 one cycle -> EMPTY, in_ready=1 next cycle, ptr=0.
//   5. Reset mid-frame: 2 lanes loaded, reset=0 one cycle -> lane_vld=0, d=0, next auto write to lane 0.
//   6. Counter: with DEMUX64_FRAME_CNT_EN, 3 handoffs -> frame_cnt=3; without it frame_cnt=0.
//      Check against 64-bit 4:1 selector: sel=k reads lane k data written in scenario 2.

Source files
------------

// File: rtl/demux64x1_4_reg.sv
// Registered 1-to-4 lane distributor: loads four WIDTH-bit lanes, then hands off the packed frame.
// Optional frame handoff counter enabled by defining DEMUX64_FRAME_CNT_EN.
module demux64x1_4_reg #(
   parameter int WIDTH = 64
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               auto_inc,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_data,
   input  logic [1:0]         in_sel,
   output logic [3:0]         lane_vld,
   output logic [4*WIDTH-1:0] d,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [15:0]        frame_cnt
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      FILL  = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t                  state_q;
   logic [3:0][WIDTH-1:0]   data_q;
   logic [3:0]              laneVld_q;
   logic [1:0]              ptr_q;

   logic [1:0]              target;
   logic [3:0]              laneVld_d;
   logic                    writeEn;

   always_comb begin
      target    = auto_inc ? ptr_q : in_sel;
      writeEn   = in_valid && in_ready;
      laneVld_d = laneVld_q | (4'b0001 << target);
   end

   // Writes are only possible outside FULL, so the 4th distinct lane is what moves the FSM to FULL;
   // an overwrite of a loaded lane leaves laneVld (and hence the state) where it was.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= EMPTY;
         data_q    <= '0;
         laneVld_q <= '0;
         ptr_q     <= '0;
      end else begin
         case (state_q)
            EMPTY, FILL: begin
               if (writeEn) begin
                  data_q[target] <= in_data;
                  laneVld_q      <= laneVld_d;
                  if (auto_inc) begin
                     ptr_q <= ptr_q + 2'd1;
                  end
                  state_q <= (laneVld_d == 4'hF) ? FULL : FILL;
               end
            end
            FULL: begin
               if (out_ready) begin
                  laneVld_q <= '0;
                  ptr_q     <= '0;
                  state_q   <= EMPTY;
               end
            end
            default: state_q <= EMPTY;
         endcase
      end
   end

   assign in_ready  = (state_q != FULL);
   assign out_valid = (state_q == FULL);
   assign lane_vld  = laneVld_q;
   assign d         = data_q;

`ifdef DEMUX64_FRAME_CNT_EN
   logic [15:0] frameCnt_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         frameCnt_q <= '0;
      end else if ((state_q == FULL) && out_ready) begin
         frameCnt_q <= frameCnt_q + 16'd1;
      end
   end

   assign frame_cnt = frameCnt_q;
`else
   assign frame_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_demux64x1_4_reg.sv
// Self-checking bench for demux64x1_4_reg: a lane model predicts d/lane_vld after every write,
// and completed frames are queued and compared at each handoff.
module tb_demux64x1_4_reg;

   localparam int WIDTH = 64;
`ifdef DEMUX64_FRAME_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic               clk;
   logic               reset;
   logic               auto_inc;
   logic               in_valid;
   logic               in_ready;
   logic [WIDTH-1:0]   in_data;
   logic [1:0]         in_sel;
   logic [3:0]         lane_vld;
   logic [4*WIDTH-1:0] d;
   logic               out_valid;
   logic               out_ready;
   logic [15:0]        frame_cnt;

   demux64x1_4_reg #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .reset     (reset),
      .auto_inc  (auto_inc),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_sel    (in_sel),
      .lane_vld  (lane_vld),
      .d         (d),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .frame_cnt (frame_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   logic [3:0][WIDTH-1:0] modelD;
   logic [3:0]            modelVld;
   logic [1:0]            modelPtr;
   logic [15:0]           modelCnt;
   logic [4*WIDTH-1:0]    frameQ[$];

   task automatic checkOutput(input string tag, input logic [255:0] actual, input logic [255:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
      end
   endtask

   // Reads lane k the way the downstream 4:1 selector does.
   function automatic logic [WIDTH-1:0] sel4(input logic [4*WIDTH-1:0] bus, input logic [1:0] k);
      return bus[WIDTH*k +: WIDTH];
   endfunction

   task automatic applyStimulus(input logic a, input logic [1:0] s, input logic [WIDTH-1:0] data);
      logic [1:0] t;
      checkOutput("inReadyBeforeWrite", in_ready, 1);
      auto_inc = a;
      in_sel   = s;
      in_data  = data;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      t = a ? modelPtr : s;
      modelD[t]   = data;
      modelVld[t] = 1'b1;
      if (a) modelPtr = modelPtr + 2'd1;
      if (modelVld == 4'hF) frameQ.push_back(modelD);
      checkOutput("laneVld", lane_vld, modelVld);
      checkOutput("dataAfterWrite", d, modelD);
      checkOutput("outValid", out_valid, (modelVld == 4'hF));
   endtask

   task automatic takeFrame();
      int waitCycles;
      logic [4*WIDTH-1:0] expFrame;
      waitCycles = 0;
      out_ready = 1'b1;
      while (!out_valid && waitCycles < 20) begin
         @(posedge clk);
         #1;
         waitCycles++;
      end
      checkOutput("handoffValid", out_valid, 1);
      expFrame = (frameQ.size() > 0) ? frameQ.pop_front() : '0;
      checkOutput("frameData", d, expFrame);
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      modelVld = '0;
      modelPtr = '0;
      modelCnt = modelCnt + 16'd1;
      checkOutput("outValidAfterHandoff", out_valid, 0);
      checkOutput("inReadyAfterHandoff", in_ready, 1);
      checkOutput("laneVldAfterHandoff", lane_vld, 0);
      checkOutput("dHeldAfterHandoff", d, modelD);
      checkOutput("frameCnt", frame_cnt, CNT_EN ? modelCnt : 16'h0);
   endtask

   initial begin
      logic [WIDTH-1:0] aWords[4];
      aWords = '{64'hA0, 64'hA1, 64'hA2, 64'hA3};

      reset     = 1'b0;
      auto_inc  = 1'b1;
      in_valid  = 1'b1;
      in_data   = 64'hFFFF_FFFF_FFFF_FFFF;
      in_sel    = 2'd0;
      out_ready = 1'b0;
      modelD    = '0;
      modelVld  = '0;
      modelPtr  = '0;
      modelCnt  = '0;

      // Reset held with a pending word: nothing may load.
      repeat (2) @(posedge clk);
      #1;
      checkOutput("resetD", d, 0);
      checkOutput("resetLaneVld", lane_vld, 0);
      checkOutput("resetOutValid", out_valid, 0);
      checkOutput("resetInReady", in_ready, 1);
      checkOutput("resetFrameCnt", frame_cnt, 0);
      in_valid = 1'b0;
      reset    = 1'b1;
      @(posedge clk);
      #1;

      $display("[TB] auto-increment fill");
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 2'd0, aWords[i]);
      checkOutput("autoFillFrame", d, {64'hA3, 64'hA2, 64'hA1, 64'hA0});
      checkOutput("autoFillInReady", in_ready, 0);
      for (int k = 0; k < 4; k++) checkOutput("selectorLane", sel4(d, 2'(k)), aWords[k]);

      $display("[TB] backpressure while full");
      auto_inc = 1'b1;
      in_data  = 64'hDEAD_BEEF;
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         checkOutput("stallD", d, modelD);
         checkOutput("stallLaneVld", lane_vld, 4'hF);
         checkOutput("stallInReady", in_ready, 0);
      end
      takeFrame();
      in_valid = 1'b0;

      $display("[TB] mixed auto/addressed words");
      applyStimulus(1'b1, 2'd3, 64'hB0);
      applyStimulus(1'b0, 2'd3, 64'hB3);
      applyStimulus(1'b1, 2'd0, 64'hB1);
      applyStimulus(1'b0, 2'd2, 64'hB2);
      checkOutput("mixedFrame", d, {64'hB3, 64'hB2, 64'hB1, 64'hB0});
      takeFrame();

      $display("[TB] addressed writes with overwrite");
      applyStimulus(1'b0, 2'd2, 64'h22);
      applyStimulus(1'b0, 2'd2, 64'h33);
      checkOutput("overwriteLaneVld", lane_vld, 4'b0100);
      checkOutput("overwriteLane2", d[191:128], 64'h33);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      checkOutput("earlyReadyIgnored", lane_vld, 4'b0100);
      applyStimulus(1'b0, 2'd0, 64'h30);
      applyStimulus(1'b0, 2'd1, 64'h31);
      applyStimulus(1'b0, 2'd3, 64'h34);
      takeFrame();

      $display("[TB] reset mid-frame");
      applyStimulus(1'b1, 2'd0, 64'hC0);
      applyStimulus(1'b1, 2'd0, 64'hC1);
      reset = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      modelD   = '0;
      modelVld = '0;
      modelPtr = '0;
      modelCnt = '0;
      frameQ.delete();
      checkOutput("midResetLaneVld", lane_vld, 0);
      checkOutput("midResetD", d, 0);
      checkOutput("midResetFrameCnt", frame_cnt, 0);
      applyStimulus(1'b1, 2'd2, 64'hC5);
      checkOutput("postResetLane0", sel4(d, 2'd0), 64'hC5);

      $display("[TB] three handoffs for the counter");
      for (int i = 1; i < 4; i++) applyStimulus(1'b1, 2'd0, {$urandom, $urandom});
      takeFrame();
      for (int f = 0; f < 2; f++) begin
         for (int i = 0; i < 4; i++) applyStimulus(1'b1, 2'(i), {$urandom, $urandom});
         takeFrame();
      end
      checkOutput("finalFrameCnt", frame_cnt, CNT_EN ? 16'd3 : 16'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
